// File: rtl/idu_pkg.sv
// ============================================================================
// idu_pkg: shared decode constants, immediate-type enum and opcode decoder.
// Rev 1.0
// ============================================================================
`default_nettype none

package idu_pkg;

  localparam logic [3:0] CMD_NOP     = 4'd0;
  localparam logic [3:0] CMD_ALU_IMM = 4'd1;
  localparam logic [3:0] CMD_ALU_REG = 4'd2;
  localparam logic [3:0] CMD_LOAD    = 4'd3;
  localparam logic [3:0] CMD_STORE   = 4'd4;
  localparam logic [3:0] CMD_BRANCH  = 4'd5;
  localparam logic [3:0] CMD_JAL     = 4'd6;
  localparam logic [3:0] CMD_JALR    = 4'd7;
  localparam logic [3:0] CMD_LUI     = 4'd8;
  localparam logic [3:0] CMD_AUIPC   = 4'd9;
  localparam logic [3:0] CMD_SYSTEM  = 4'd10;
  localparam logic [3:0] CMD_ILLEGAL = 4'd15;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5,
    IMM_N = 3'd6
  } imm_type_e;

  function automatic logic [3:0] decode_cmd(input logic [6:0] opcode);
    logic [3:0] cmd;
    cmd = CMD_ILLEGAL;
    case (opcode)
      OP_REG:    cmd = CMD_ALU_REG;
      OP_IMM:    cmd = CMD_ALU_IMM;
      OP_LOAD:   cmd = CMD_LOAD;
      OP_STORE:  cmd = CMD_STORE;
      OP_BRANCH: cmd = CMD_BRANCH;
      OP_JAL:    cmd = CMD_JAL;
      OP_JALR:   cmd = CMD_JALR;
      OP_LUI:    cmd = CMD_LUI;
      OP_AUIPC:  cmd = CMD_AUIPC;
      OP_SYSTEM: cmd = CMD_SYSTEM;
      default:   cmd = CMD_ILLEGAL;
    endcase
    return cmd;
  endfunction

  // SYSTEM carries an I-format immediate (funct12), like the CSR/ebreak forms.
  function automatic imm_type_e imm_type_of(input logic [3:0] cmd);
    imm_type_e t;
    t = IMM_N;
    case (cmd)
      CMD_ALU_IMM, CMD_LOAD, CMD_JALR, CMD_SYSTEM: t = IMM_I;
      CMD_STORE:                                   t = IMM_S;
      CMD_BRANCH:                                  t = IMM_B;
      CMD_LUI, CMD_AUIPC:                          t = IMM_U;
      CMD_JAL:                                     t = IMM_J;
      CMD_ALU_REG:                                 t = IMM_R;
      default:                                     t = IMM_N;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/idu_imm_gen.sv
// ============================================================================
// idu_imm_gen: combinational RV32I immediate generator (I/S/B/U/J formats).
// Rev 1.0
// ============================================================================
`default_nettype none

module idu_imm_gen
  import idu_pkg::*;
(
  input  logic [31:0] inst,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^inst[6:0];

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/idu_stage.sv
// ============================================================================
// idu_stage: registered RV32I decode stage with valid/ready handshake.
// Rev 1.0 -- optional perf counters enabled by IDU_PERF_CNT_EN.
// ============================================================================
`default_nettype none

module idu_stage
  import idu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [31:0]           in_inst,
  output logic [ADDR_WIDTH-1:0] raddr1,
  output logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_src1,
  output logic [DATA_WIDTH-1:0] out_src2,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic [31:0]           out_imm,
  output logic [CMD_WIDTH-1:0]  out_cmd,
  output logic                  out_illegal,
  output logic                  halt_req,
  output logic [31:0]           perf_inst_cnt,
  output logic [31:0]           perf_stall_cnt
);

  logic [3:0]  cmd;
  imm_type_e   imm_type;
  logic [31:0] imm;
  logic        reg_bad;
  logic        illegal;
  logic        accept;
  logic        handshake;
  logic        is_ebreak;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  assign raddr1 = in_inst[15 +: ADDR_WIDTH];
  assign raddr2 = in_inst[20 +: ADDR_WIDTH];

  assign cmd      = decode_cmd(in_inst[6:0]);
  assign imm_type = imm_type_of(cmd);

  idu_imm_gen u_imm_gen (
    .inst     (in_inst),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // RV32E: register indices above 15 do not exist.
  generate
    if (ADDR_WIDTH < 5) begin : g_rv32e
      assign reg_bad = in_inst[11] | in_inst[19] | in_inst[24];
    end else begin : g_rv32i
      assign reg_bad = 1'b0;
    end
  endgenerate

  assign illegal  = (cmd == CMD_ILLEGAL) || (in_inst[1:0] != 2'b11) || reg_bad;
  assign halt_req = handshake && is_ebreak && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_cmd     <= '0;
      out_illegal <= 1'b0;
      is_ebreak   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_src1    <= rdata1;
      out_src2    <= rdata2;
      out_rd      <= in_inst[7 +: ADDR_WIDTH];
      out_imm     <= imm;
      out_cmd     <= CMD_WIDTH'(cmd);
      out_illegal <= illegal;
      is_ebreak   <= (in_inst == EBREAK);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef IDU_PERF_CNT_EN
  logic [31:0] inst_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake)
        inst_cnt <= inst_cnt + 32'd1;
      if (out_valid && !out_ready)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_inst_cnt  = inst_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_inst_cnt  = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idu_stage.sv
// ============================================================================
// tb_idu_stage: directed scenarios plus randomized traffic against a reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_idu_stage;

  localparam int AW = 5;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_src1, out_src2, out_imm;
  logic [4:0]  out_rd;
  logic [3:0]  out_cmd;
  logic        out_illegal;
  logic        halt_req;
  logic [31:0] perf_inst_cnt, perf_stall_cnt;

  logic [31:0] rf [32];
  logic [6:0]  ops [10];

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  cmd;
    logic        ill;
    logic        ebreak;
  } exp_t;

  always #5 clk = ~clk;

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  idu_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_src1       (out_src1),
    .out_src2       (out_src2),
    .out_rd         (out_rd),
    .out_imm        (out_imm),
    .out_cmd        (out_cmd),
    .out_illegal    (out_illegal),
    .halt_req       (halt_req),
    .perf_inst_cnt  (perf_inst_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // Reference decode: values derived from the instruction-set definition with signed arithmetic.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    int   fmt;
    int   v;
    e      = '0;
    e.pc   = pc;
    e.src1 = rf[inst[19:15]];
    e.src2 = rf[inst[24:20]];
    e.rd   = inst[11:7];
    fmt    = 0;
    case (inst[6:0])
      7'h33: begin e.cmd = 4'd2;  fmt = 0; end
      7'h13: begin e.cmd = 4'd1;  fmt = 1; end
      7'h03: begin e.cmd = 4'd3;  fmt = 1; end
      7'h23: begin e.cmd = 4'd4;  fmt = 2; end
      7'h63: begin e.cmd = 4'd5;  fmt = 3; end
      7'h6F: begin e.cmd = 4'd6;  fmt = 5; end
      7'h67: begin e.cmd = 4'd7;  fmt = 1; end
      7'h37: begin e.cmd = 4'd8;  fmt = 4; end
      7'h17: begin e.cmd = 4'd9;  fmt = 4; end
      7'h73: begin e.cmd = 4'd10; fmt = 1; end
      default: begin e.cmd = 4'd15; fmt = 0; end
    endcase
    case (fmt)
      1: begin v = $signed(inst[31:20]); e.imm = v; end
      2: begin v = $signed({inst[31:25], inst[11:7]}); e.imm = v; end
      3: begin v = $signed({inst[31], inst[7], inst[30:25], inst[11:8]}); e.imm = v * 2; end
      4: e.imm = inst & 32'hFFFF_F000;
      5: begin v = $signed({inst[31], inst[19:12], inst[20], inst[30:21]}); e.imm = v * 2; end
      default: e.imm = 32'd0;
    endcase
    e.ill = (e.cmd == 4'd15) || (inst[1:0] != 2'b11) ||
            ((AW < 5) && (inst[11] || inst[19] || inst[24]));
    e.ebreak = (inst == EBRK);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0)      return EBRK;
    else if (k == 1) return r;
    else             return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
    total++;
    if ({out_valid, halt_req, out_illegal} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {out_valid, halt_req, out_illegal});
    else passed++;
    total++;
    if ({out_pc, out_src1, out_src2, out_imm, out_rd, out_cmd} !== '0)
      $display("FAIL reset_payload got pc=%h s1=%h s2=%h imm=%h rd=%h cmd=%h want all 0", out_pc, out_src1, out_src2, out_imm, out_rd, out_cmd);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else passed++;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(32'h0050_0093, 32'h0000_1000);
    #1;
    total++;
    if (raddr1 !== 5'd0) $display("FAIL addi_raddr1 got=%0d want=0", raddr1);
    else passed++;
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_rd, out_imm, out_cmd, out_illegal, out_src1, out_pc} !== {1'b1, 5'd1, 32'h5, 4'd1, 1'b0, 32'h0, 32'h1000})
      $display("FAIL addi_decode got v=%b rd=%0d imm=%h cmd=%0d ill=%b s1=%h pc=%h want v=1 rd=1 imm=5 cmd=1 ill=0 s1=0 pc=1000",
               out_valid, out_rd, out_imm, out_cmd, out_illegal, out_src1, out_pc);
    else passed++;
    cyc();
    total++;
    if (out_valid !== 1'b0) $display("FAIL addi_drain got=%b want=0", out_valid);
    else passed++;
  endtask

  task automatic test_store();
    drive(32'hFE20_AE23, 32'h0000_1004);
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_imm, out_cmd, out_src1, out_src2} !== {32'hFFFF_FFFC, 4'd4, 32'h100, 32'hAB})
      $display("FAIL sw_decode got imm=%h cmd=%0d s1=%h s2=%h want imm=fffffffc cmd=4 s1=100 s2=ab", out_imm, out_cmd, out_src1, out_src2);
    else passed++;
    cyc();
  endtask

  task automatic test_back_to_back();
    drive(32'h0080_00EF, 32'h0000_2000);
    cyc();
    drive(32'hFE00_0CE3, 32'h0000_2004);
    total++;
    if ({out_valid, out_imm, out_cmd} !== {1'b1, 32'h8, 4'd6})
      $display("FAIL b2b_jal got v=%b imm=%h cmd=%0d want v=1 imm=8 cmd=6", out_valid, out_imm, out_cmd);
    else passed++;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%b want=1", in_ready);
    else passed++;
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_imm, out_cmd, out_pc} !== {1'b1, 32'hFFFF_FFF8, 4'd5, 32'h2004})
      $display("FAIL b2b_beq got v=%b imm=%h cmd=%0d pc=%h want v=1 imm=fffffff8 cmd=5 pc=2004", out_valid, out_imm, out_cmd, out_pc);
    else passed++;
    cyc();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(32'h0050_0093, 32'h0000_0200);
    cyc();
    drive(32'hFE20_AE23, 32'h0000_0204);
    repeat (3) begin
      #1;
      total++;
      if ({in_ready, out_valid, out_pc, out_imm} !== {1'b0, 1'b1, 32'h200, 32'h5})
        $display("FAIL stall_hold got rdy=%b v=%b pc=%h imm=%h want rdy=0 v=1 pc=200 imm=5", in_ready, out_valid, out_pc, out_imm);
      else passed++;
      cyc();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready got=%b want=1", in_ready);
    else passed++;
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_pc, out_imm} !== {1'b1, 32'h204, 32'hFFFF_FFFC})
      $display("FAIL stall_next got v=%b pc=%h imm=%h want v=1 pc=204 imm=fffffffc", out_valid, out_pc, out_imm);
    else passed++;
    cyc();
  endtask

  task automatic test_ebreak();
    out_ready = 1'b0;
    drive(EBRK, 32'h0000_0300);
    cyc();
    in_valid = 1'b0;
    repeat (2) begin
      #1;
      total++;
      if ({halt_req, out_valid} !== 2'b01) $display("FAIL ebreak_stalled got halt=%b v=%b want halt=0 v=1", halt_req, out_valid);
      else passed++;
      cyc();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (halt_req !== 1'b1) $display("FAIL ebreak_pulse got=%b want=1", halt_req);
    else passed++;
    cyc();
    total++;
    if ({halt_req, out_valid} !== 2'b00) $display("FAIL ebreak_after got halt=%b v=%b want 00", halt_req, out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(EBRK, 32'h0000_0400);
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    total++;
    if (halt_req !== 1'b0) $display("FAIL flush_halt got=%b want=0", halt_req);
    else passed++;
    cyc();
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid got=%b want=0", out_valid);
    else passed++;
    drive(32'h0050_0093, 32'h0000_0404);
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL flush_accept_ready got=%b want=1", in_ready);
    else passed++;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_drops got=%b want=0", out_valid);
    else passed++;
  endtask

  task automatic test_illegal();
    drive(32'h0000_007F, 32'h0000_0500);
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_cmd, out_illegal} !== {1'b1, 4'd15, 1'b1})
      $display("FAIL illegal_op got v=%b cmd=%0d ill=%b want v=1 cmd=15 ill=1", out_valid, out_cmd, out_illegal);
    else passed++;
    cyc();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(32'h0050_0093, 32'h0000_0600);
    cyc();
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, halt_req, out_imm} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL async_reset got v=%b halt=%b imm=%h want 0 0 0", out_valid, halt_req, out_imm);
    else passed++;
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL post_reset got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    else passed++;
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    logic        mv;
    exp_t        me;
    exp_t        act;
    logic        acc;
    int          hs;
    int          st;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc();
    rst = 1'b1;
    mv = 1'b0; me = '0; hs = 0; st = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_inst   = rand_inst();
      in_pc     = $urandom;
      #1;
      total++;
      if ({in_ready, halt_req, raddr1, raddr2} !==
          {(!mv || out_ready), (mv && out_ready && me.ebreak && !flush), in_inst[19:15], in_inst[24:20]})
        $display("FAIL rnd_comb[%0d] got rdy=%b halt=%b ra1=%0d ra2=%0d want rdy=%b halt=%b ra1=%0d ra2=%0d", i,
                 in_ready, halt_req, raddr1, raddr2, (!mv || out_ready), (mv && out_ready && me.ebreak && !flush),
                 in_inst[19:15], in_inst[24:20]);
      else passed++;
      if (mv && out_ready)  hs++;
      if (mv && !out_ready) st++;
      acc = in_valid && (!mv || out_ready);
      if (flush)          mv = 1'b0;
      else if (acc)       begin mv = 1'b1; me = model(in_inst, in_pc); end
      else if (out_ready) mv = 1'b0;
      cyc();
      total++;
      if (out_valid !== mv) $display("FAIL rnd_valid[%0d] got=%b want=%b", i, out_valid, mv);
      else passed++;
      if (mv) begin
        act = {out_pc, out_src1, out_src2, out_imm, out_rd, out_cmd, out_illegal, me.ebreak};
        total++;
        if (act !== me)
          $display("FAIL rnd_payload[%0d] got pc=%h s1=%h s2=%h imm=%h rd=%0d cmd=%0d ill=%b want pc=%h s1=%h s2=%h imm=%h rd=%0d cmd=%0d ill=%b",
                   i, out_pc, out_src1, out_src2, out_imm, out_rd, out_cmd, out_illegal,
                   me.pc, me.src1, me.src2, me.imm, me.rd, me.cmd, me.ill);
        else passed++;
      end
    end
    in_valid = 1'b0; flush = 1'b0;
    #1;
`ifdef IDU_PERF_CNT_EN
    total++;
    if ({perf_inst_cnt, perf_stall_cnt} !== {32'(hs), 32'(st)})
      $display("FAIL perf_counts got inst=%0d stall=%0d want inst=%0d stall=%0d", perf_inst_cnt, perf_stall_cnt, hs, st);
    else passed++;
`else
    total++;
    if ({perf_inst_cnt, perf_stall_cnt} !== 64'd0)
      $display("FAIL perf_disabled got inst=%0d stall=%0d want 0 0 (seen %0d/%0d)", perf_inst_cnt, perf_stall_cnt, hs, st);
    else passed++;
`endif
  endtask

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    rf[0] = 32'd0;
    for (int r = 1; r < 32; r++) rf[r] = $urandom;
    rf[1] = 32'h100;
    rf[2] = 32'hAB;
    test_reset();
    test_addi();
    test_store();
    test_back_to_back();
    test_stall();
    test_ebreak();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
